// File: rtl/pixel_alu_pipe.sv
// pixel_alu_pipe: two-stage valid/ready per-pixel ALU (invert, pseudo-colour, threshold,
// clamp, saturating brightness) with per-pixel captured configuration and an output counter.
module pixel_alu_pipe #(
    parameter int CH_W   = 4,
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*CH_W-1:0]   pixel_in,
    input  logic [2:0]               func,
    input  logic [CH_W-1:0]          thresh,
    input  logic [NUM_CH*CH_W-1:0]   max,
    input  logic [NUM_CH*CH_W-1:0]   min,
    input  logic [CH_W:0]            offset,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*CH_W-1:0]   pixel_out,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         out_cnt
);
    localparam int PW = NUM_CH * CH_W;
    localparam logic [CH_W-1:0] ONES = '1;

    logic            r_s1_valid, r_s2_valid;
    logic [PW-1:0]   r_s1_pix, r_s1_max, r_s1_min, r_s2_pix;
    logic [2:0]      r_s1_func;
    logic [CH_W-1:0] r_s1_thresh;
    logic [CH_W:0]   r_s1_off;
    logic [CNT_W-1:0] r_cnt;
    logic            w_s1_ready, w_s2_ready;
    logic [PW-1:0]   w_res;
    logic [3:0]      w_g;
    logic [2:0]      w_pc_mask;

    assign w_s2_ready = !r_s2_valid | out_ready;
    assign w_s1_ready = !r_s1_valid | w_s2_ready;
    assign in_ready   = w_s1_ready;
    assign out_valid  = r_s2_valid;
    assign pixel_out  = r_s2_pix;
    assign out_cnt    = r_cnt;

    // Pseudo-colour bands on the top nibble of green: which of ch0..ch2 light up
    assign w_g       = r_s1_pix[2*CH_W-1 -: 4];
    assign w_pc_mask = (w_g <= 4'd2)  ? 3'b000 :
                       (w_g <= 4'd4)  ? 3'b001 :
                       (w_g <= 4'd9)  ? 3'b010 :
                       (w_g <= 4'd13) ? 3'b100 : 3'b111;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CH_W-1:0] w_c, w_mn, w_mx, w_pc, w_bright;
        logic [CH_W+1:0] w_sum;
        assign w_c  = r_s1_pix[k*CH_W +: CH_W];
        assign w_mn = r_s1_min[k*CH_W +: CH_W];
        assign w_mx = r_s1_max[k*CH_W +: CH_W];
        // Zero-extended channel plus sign-extended offset; bit CH_W+1 is the sign
        assign w_sum    = {2'b00, w_c} + {r_s1_off[CH_W], r_s1_off};
        assign w_bright = w_sum[CH_W+1] ? '0 : w_sum[CH_W] ? ONES : w_sum[CH_W-1:0];
        if (k < 3) begin : g_pc
            assign w_pc = {CH_W{w_pc_mask[k]}};
        end else begin : g_npc
            assign w_pc = '0;
        end
        assign w_res[k*CH_W +: CH_W] =
            (r_s1_func == 3'd0) ? ~w_c :
            (r_s1_func == 3'd1) ? w_pc :
            (r_s1_func == 3'd3) ? ((w_c > r_s1_thresh) ? ONES : '0) :
            (r_s1_func == 3'd4) ? ((w_c < w_mn) ? w_mn : (w_c > w_mx) ? w_mx : w_c) :
            (r_s1_func == 3'd5) ? w_bright : w_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_max    <= '0;
            r_s1_min    <= '0;
            r_s1_func   <= '0;
            r_s1_thresh <= '0;
            r_s1_off    <= '0;
            r_s2_pix    <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_s1_ready) r_s1_valid <= in_valid;
            if (in_valid && w_s1_ready) begin
                r_s1_pix    <= pixel_in;
                r_s1_func   <= func;
                r_s1_thresh <= thresh;
                r_s1_max    <= max;
                r_s1_min    <= min;
                r_s1_off    <= offset;
            end
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (r_s1_valid && w_s2_ready) r_s2_pix <= w_res;
            if (cnt_clr) r_cnt <= '0;
            else if (r_s2_valid && out_ready) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pixel_alu_pipe.sv
// tb_pixel_alu_pipe: scoreboard bench; the driver pushes expected pixels on acceptance,
// a negedge monitor pops and compares on every output transfer.
module tb_pixel_alu_pipe;
    logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1, cnt_clr = 0;
    logic        in_ready, out_valid;
    logic [11:0] pixel_in = 0, mx = 0, mn = 0, pixel_out;
    logic [2:0]  func = 0;
    logic [3:0]  thresh = 0;
    logic [4:0]  offset = 0;
    logic [15:0] out_cnt;
    int          checks = 0, errors = 0;
    logic [11:0] sb[$];
    bit          rand_bp = 0, stalled = 0;
    logic [11:0] held = 0;

    pixel_alu_pipe #(.CH_W(4), .NUM_CH(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pixel_in(pixel_in), .func(func), .thresh(thresh), .max(mx), .min(mn),
        .offset(offset), .out_valid(out_valid), .out_ready(out_ready),
        .pixel_out(pixel_out), .cnt_clr(cnt_clr), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input logic [11:0] p, input logic [2:0] f,
                                          input logic [3:0] th, input logic [11:0] hi, lo,
                                          input logic [4:0] off);
        int ch, h, l, v, o, g;
        logic [11:0] r;
        r = '0;
        o = int'(off);
        if (o >= 16) o -= 32;
        g = int'(p[7:4]);
        for (int c = 0; c < 3; c++) begin
            ch = (int'(p) >> (4*c)) & 15;
            h  = (int'(hi) >> (4*c)) & 15;
            l  = (int'(lo) >> (4*c)) & 15;
            case (f)
                3'd0: v = 15 - ch;
                3'd1: v = (g >= 14 || (c == 0 && g >= 3 && g <= 4) ||
                           (c == 1 && g >= 5 && g <= 9) || (c == 2 && g >= 10 && g <= 13)) ? 15 : 0;
                3'd3: v = (ch > int'(th)) ? 15 : 0;
                3'd4: v = (ch < l) ? l : (ch > h) ? h : ch;
                3'd5: begin
                    v = ch + o;
                    if (v < 0) v = 0;
                    if (v > 15) v = 15;
                end
                default: v = ch;
            endcase
            r = r | (12'(v) << (4*c));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_acc(input logic [11:0] exp);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept: in_ready stayed 0 for 200 cycles");
        in_valid = 0;
    endtask

    task automatic send(input logic [11:0] p, input logic [2:0] f, input logic [11:0] exp);
        pixel_in = p;
        func     = f;
        in_valid = 1;
        wait_acc(exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_bp) out_ready = ($urandom % 4) != 0;
    end

    always @(negedge clk) begin
        if (rst) stalled = 0;
        else begin
            if (stalled && out_valid) chk("stall_hold", pixel_out, held);
            stalled = out_valid && !out_ready;
            held    = pixel_out;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pix: unexpected output %h with empty scoreboard", pixel_out);
                end else chk("pix", pixel_out, sb.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [11:0] r;
        logic [3:0]  g_tab [5] = '{4'h2, 4'h4, 4'h9, 4'hD, 4'hE};
        logic [11:0] pc_tab[5] = '{12'h000, 12'h00F, 12'h0F0, 12'hF00, 12'hFFF};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_out_cnt", out_cnt, 0);
        rst = 0;
        @(posedge clk);
        #1;
        // latency: accepted at edge E0, visible after E1
        send(12'h3A5, 3'd0, 12'hC5A);
        in_valid = 0;
        chk("lat_c1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_c2_valid", out_valid, 1);
        chk("lat_c2_pix", pixel_out, 12'hC5A);
        drain();
        for (int v = 0; v < 4096; v++) send(12'(v), 3'd0, ~12'(v));
        in_valid = 0;
        drain();
        for (int i = 0; i < 5; i++) begin
            r = 12'($urandom);
            send({r[11:8], g_tab[i], r[3:0]}, 3'd1, pc_tab[i]);
        end
        thresh = 4'h7;  send(12'h8F7, 3'd3, 12'hFF0);
        thresh = 4'h8;  send(12'h8F7, 3'd3, 12'h0F0);
        mn = 12'h111; mx = 12'hCCC;
        send(12'h0F5, 3'd4, 12'h1C5);
        send(12'hD00, 3'd4, 12'hC11);
        offset = 5'd3;      send(12'hE02, 3'd5, 12'hF35);
        offset = 5'b11101;  send(12'h2A1, 3'd5, 12'h070);
        offset = 5'b10000;  send(12'hFFF, 3'd5, 12'h000);
        in_valid = 0;
        drain();
        // backpressure with per-beat func and config changes
        cnt_clr = 1;
        @(posedge clk);
        #1;
        cnt_clr = 0;
        chk("cnt_clr_idle", out_cnt, 0);
        thresh = 4'h7; mn = 12'h111; mx = 12'hCCC; offset = 5'b11101;
        out_ready = 0;
        send(12'h3A5, 3'd0, 12'hC5A);
        send(12'h8F7, 3'd3, 12'hFF0);
        in_valid = 0;
        thresh = 4'hF;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1;
        send(12'h0F5, 3'd4, 12'h1C5);
        send(12'h2A1, 3'd5, 12'h070);
        in_valid = 0;
        drain();
        chk("cnt_after_4", out_cnt, 4);
        // clear coinciding with an output transfer
        send(12'h123, 3'd2, 12'h123);
        in_valid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        cnt_clr = 1;
        @(posedge clk);
        #1;
        cnt_clr = 0;
        chk("cnt_clr_xfer", out_cnt, 0);
        drain();
        // randomized traffic with random backpressure
        rand_bp = 1;
        for (int i = 0; i < 400; i++) begin
            thresh = 4'($urandom); mx = 12'($urandom); mn = 12'($urandom); offset = 5'($urandom);
            pixel_in = 12'($urandom);
            func = 3'($urandom);
            in_valid = 1;
            wait_acc(model(pixel_in, func, thresh, mx, mn, offset));
            if ($urandom % 4 == 0) begin
                in_valid = 0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 0;
        rand_bp = 0;
        out_ready = 1;
        drain();
        // asynchronous reset with two pixels in flight
        out_ready = 0;
        send(12'h111, 3'd2, 12'h111);
        send(12'h222, 3'd2, 12'h222);
        in_valid = 0;
        #2;
        rst = 1;
        #1;
        chk("amid_rst_valid", out_valid, 0);
        chk("amid_rst_pix", pixel_out, 0);
        chk("amid_rst_cnt", out_cnt, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        send(12'h5A5, 3'd0, 12'hA5A);
        in_valid = 0;
        chk("post_rst_c1_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("post_rst_c2_valid", out_valid, 1);
        chk("post_rst_c2_pix", pixel_out, 12'hA5A);
        drain();
        // counter wrap
        cnt_clr = 1;
        @(posedge clk);
        #1;
        cnt_clr = 0;
        for (int i = 0; i < 65535; i++) send(12'(i), 3'd2, 12'(i));
        in_valid = 0;
        drain();
        chk("cnt_ffff", out_cnt, 16'hFFFF);
        send(12'hABC, 3'd6, 12'hABC);
        in_valid = 0;
        drain();
        chk("cnt_wrap", out_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
